entropy_block_scheduler: RTL

Sequences quantized, zig-zag-ordered 8x8 coefficient blocks from the Y and Cb/Cr block buffers into the entropy encoder, one MCU at a time. It drives the encoder's data, valid, block-start, component-select and enable inputs, and propagates downstream backpressure as the encoder enable. It counts encoder end-of-block pulses and signals frame completion once the pipeline has drained.

---
 rtl/entropy_block_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/entropy_block_scheduler.sv
// Streams zig-zag coefficient blocks (Y x Y_PER_MCU, Cb, Cr per MCU) from the block
// buffers into the entropy encoder and signals frame completion after the last EOB.
module entropy_block_scheduler #(
  parameter int Y_PER_MCU = 4
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_start,
  input  logic [15:0] I_mcu_total,
  input  logic        I_y_ready,
  input  logic        I_c_ready,
  input  logic [7:0]  I_rd_data,
  input  logic        I_out_ready,
  input  logic        I_eob,
  output logic        O_rd_en,
  output logic [5:0]  O_rd_addr,
  output logic [1:0]  O_rd_sel,
  output logic        O_y_release,
  output logic        O_c_release,
  output logic        O_en,
  output logic [7:0]  O_data,
  output logic        O_data_valid,
  output logic        O_block_update,
  output logic        O_yc,
  output logic        O_br,
  output logic        O_busy,
  output logic        O_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUF,
    ST_STREAM,
    ST_RELEASE,
    ST_DRAIN,
    ST_FINISH
  } state_e;

  localparam logic [2:0]  LAST_BLK    = 3'(Y_PER_MCU + 1);
  localparam logic [19:0] BLK_PER_MCU = 20'(Y_PER_MCU + 2);

  // Buffer select for a block position inside the MCU.
  function automatic logic [1:0] sel_of(input logic [2:0] idx);
    if (idx < 3'(Y_PER_MCU))       return 2'd0;
    else if (idx == 3'(Y_PER_MCU)) return 2'd1;
    else                           return 2'd2;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] mcu_total_q, mcu_total_d;
  logic [19:0] total_blk_q, total_blk_d;
  logic [15:0] mcu_cnt_q, mcu_cnt_d;
  logic [2:0]  blk_idx_q, blk_idx_d;
  logic [5:0]  addr_q, addr_d;
  logic [1:0]  sel_q, sel_d;
  logic        pending_q, pending_d;
  logic        pend_dc_q, pend_dc_d;
  logic [19:0] eob_cnt_q, eob_cnt_d;
  logic        done_q;

  logic       rd_en;
  logic       y_rel;
  logic       c_rel;
  logic [2:0] blk_next;
  logic       last_frame_blk;

  // NOTE: every signal written here gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_d        = state_q;
    mcu_total_d    = mcu_total_q;
    total_blk_d    = total_blk_q;
    mcu_cnt_d      = mcu_cnt_q;
    blk_idx_d      = blk_idx_q;
    addr_d         = addr_q;
    sel_d          = sel_q;
    eob_cnt_d      = eob_cnt_q + 20'(I_eob && I_out_ready);
    y_rel          = 1'b0;
    c_rel          = 1'b0;
    rd_en          = (state_q == ST_STREAM) && I_out_ready;
    blk_next       = (blk_idx_q == LAST_BLK) ? 3'd0 : blk_idx_q + 3'd1;
    last_frame_blk = (blk_idx_q == LAST_BLK) && (mcu_cnt_q == mcu_total_q - 16'd1);

    case (state_q)
      ST_IDLE: begin
        if (I_start) begin
          mcu_total_d = I_mcu_total;
          total_blk_d = 20'(I_mcu_total) * BLK_PER_MCU;
          mcu_cnt_d   = '0;
          blk_idx_d   = '0;
          sel_d       = 2'd0;
          addr_d      = '0;
          eob_cnt_d   = '0;
          state_d     = (I_mcu_total == 16'd0) ? ST_FINISH : ST_WAIT_BUF;
        end
      end
      ST_WAIT_BUF: begin
        // Cr shares the pair flag already checked for Cb, so it proceeds unconditionally.
        if ((sel_q == 2'd0) ? I_y_ready : ((sel_q == 2'd1) ? I_c_ready : 1'b1))
          state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (rd_en) begin
          addr_d = addr_q + 6'd1;
          if (addr_q == 6'd63) state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!pending_q) begin
          y_rel     = (sel_q == 2'd0);
          c_rel     = (sel_q == 2'd2);
          blk_idx_d = blk_next;
          sel_d     = sel_of(blk_next);
          if (blk_idx_q == LAST_BLK) mcu_cnt_d = mcu_cnt_q + 16'd1;
          state_d   = last_frame_blk ? ST_DRAIN : ST_WAIT_BUF;
        end
      end
      ST_DRAIN: begin
        if (eob_cnt_d == total_blk_q) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // A read can only issue while the encoder is enabled, so any held word is consumed by it.
    pending_d = rd_en || (pending_q && !I_out_ready);
    pend_dc_d = rd_en ? (addr_q == 6'd0) : pend_dc_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= ST_IDLE;
      mcu_total_q <= '0;
      total_blk_q <= '0;
      mcu_cnt_q   <= '0;
      blk_idx_q   <= '0;
      addr_q      <= '0;
      sel_q       <= '0;
      pending_q   <= 1'b0;
      pend_dc_q   <= 1'b0;
      eob_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcu_total_q <= mcu_total_d;
      total_blk_q <= total_blk_d;
      mcu_cnt_q   <= mcu_cnt_d;
      blk_idx_q   <= blk_idx_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      pending_q   <= pending_d;
      pend_dc_q   <= pend_dc_d;
      eob_cnt_q   <= eob_cnt_d;
      done_q      <= (state_q == ST_FINISH);
    end
  end

  assign O_rd_en        = rd_en;
  assign O_rd_addr      = addr_q;
  assign O_rd_sel       = sel_q;
  assign O_y_release    = y_rel;
  assign O_c_release    = c_rel;
  assign O_en           = I_out_ready;
  assign O_data         = I_rd_data;
  assign O_data_valid   = pending_q;
  assign O_block_update = pending_q && pend_dc_q;
  assign O_yc           = (sel_q != 2'd0);
  assign O_br           = (sel_q == 2'd2);
  assign O_busy         = (state_q != ST_IDLE);
  assign O_done         = done_q;

endmodule
